// File: rtl/mux_nto1_reg.sv
// N-to-1 multiplexer with one registered output word: explicit select (MODE 0) or round-robin (MODE 1).
// Latency: 1 cycle from input handshake to out_valid; sustains one word per cycle.
// Backpressure: a word loads when the output slot is empty or draining this cycle; otherwise no in_ready.
module mux_nto1_reg #(
  parameter int WIDTH = 24,
  parameter int N     = 4,
  parameter int MODE  = 0,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    grant_idx
);

  // Output register and arbitration pointer
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SELW-1:0]  r_grant_idx;
  logic [SELW-1:0]  r_rr_ptr;

  // Combinational selection results
  logic             w_slot_free;
  logic             w_chosen;
  logic [SELW-1:0]  w_c;
  logic             w_xfer;
  logic [N-1:0]     w_ready;
  logic [WIDTH-1:0] w_data;

  // The slot can take a word when it is empty or its current word leaves this cycle
  assign w_slot_free = !r_out_valid || out_ready;

  // Pick the candidate channel: sel in MODE 0, first valid after rr_ptr in MODE 1
  always_comb begin
    w_chosen = 1'b0;
    w_c      = '0;
    if (MODE == 0) begin
      if (N == 1) begin
        // Only one source exists, so it is always the candidate.
        w_chosen = 1'b1;
      end else if (int'(sel) < N) begin
        w_chosen = 1'b1;
        w_c      = sel;
      end
    end else begin
      // Scan starts one past the last granted channel so every valid source gets a turn.
      for (int k = 1; k <= N; k++) begin
        if (!w_chosen && in_valid[(int'(r_rr_ptr) + k) % N]) begin
          w_chosen = 1'b1;
          w_c      = SELW'((int'(r_rr_ptr) + k) % N);
        end
      end
    end
  end

  // One-hot ready toward the candidate channel only when the slot can accept
  always_comb begin
    w_ready = '0;
    if (w_slot_free && w_chosen) begin
      w_ready[w_c] = 1'b1;
    end
  end

  assign w_xfer   = w_slot_free && w_chosen && in_valid[w_c];
  assign w_data   = in_data[int'(w_c)*WIDTH +: WIDTH];
  assign in_ready = w_ready;

  // Load on transfer, empty the slot when it drains with nothing behind it, hold on stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_grant_idx <= '0;
      r_rr_ptr    <= SELW'(N - 1);
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_grant_idx <= w_c;
      if (MODE == 1) begin
        r_rr_ptr <= w_c;
      end
    end else if (w_slot_free) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign grant_idx = r_grant_idx;

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Bench for mux_nto1_reg: directed scenarios on 4- and 3-channel instances plus
// randomized streaming on a 5-channel round-robin and a 1-channel 8-bit instance.
module tb_mux_nto1_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  // Instance A: MODE 0, N=4, WIDTH=24
  logic [95:0] a_data;  logic [3:0] a_valid, a_ready; logic [1:0] a_sel;
  logic [23:0] a_odata; logic a_ovalid, a_oready;     logic [1:0] a_grant;
  // Instance B: MODE 1, N=4, WIDTH=24
  logic [95:0] b_data;  logic [3:0] b_valid, b_ready; logic [1:0] b_sel;
  logic [23:0] b_odata; logic b_ovalid, b_oready;     logic [1:0] b_grant;
  // Instance C: MODE 0, N=3, WIDTH=24
  logic [71:0] c_data;  logic [2:0] c_valid, c_ready; logic [1:0] c_sel;
  logic [23:0] c_odata; logic c_ovalid, c_oready;     logic [1:0] c_grant;
  // Instance E: MODE 1, N=5, WIDTH=24
  logic [119:0] e_data; logic [4:0] e_valid, e_ready; logic [2:0] e_sel;
  logic [23:0] e_odata; logic e_ovalid, e_oready;     logic [2:0] e_grant;
  // Instance F: MODE 0, N=1, WIDTH=8
  logic [7:0] f_data;   logic [0:0] f_valid, f_ready; logic [0:0] f_sel;
  logic [7:0] f_odata;  logic f_ovalid, f_oready;     logic [0:0] f_grant;

  mux_nto1_reg #(.WIDTH(24), .N(4), .MODE(0)) u_a (
    .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .sel(a_sel), .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_oready), .grant_idx(a_grant));
  mux_nto1_reg #(.WIDTH(24), .N(4), .MODE(1)) u_b (
    .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .sel(b_sel), .out_data(b_odata), .out_valid(b_ovalid), .out_ready(b_oready), .grant_idx(b_grant));
  mux_nto1_reg #(.WIDTH(24), .N(3), .MODE(0)) u_c (
    .clk(clk), .reset(reset), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
    .sel(c_sel), .out_data(c_odata), .out_valid(c_ovalid), .out_ready(c_oready), .grant_idx(c_grant));
  mux_nto1_reg #(.WIDTH(24), .N(5), .MODE(1)) u_e (
    .clk(clk), .reset(reset), .in_data(e_data), .in_valid(e_valid), .in_ready(e_ready),
    .sel(e_sel), .out_data(e_odata), .out_valid(e_ovalid), .out_ready(e_oready), .grant_idx(e_grant));
  mux_nto1_reg #(.WIDTH(8), .N(1), .MODE(0)) u_f (
    .clk(clk), .reset(reset), .in_data(f_data), .in_valid(f_valid), .in_ready(f_ready),
    .sel(f_sel), .out_data(f_odata), .out_valid(f_ovalid), .out_ready(f_oready), .grant_idx(f_grant));

  // Scoreboards
  typedef struct {int ch; logic [23:0] d;} exp_t;
  logic [23:0] qa[$];
  int          qg[$];
  exp_t        q5[$];
  logic [7:0]  q1[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_data = '0; a_valid = '0; a_sel = '0; a_oready = 1'b0;
    b_data = '0; b_valid = '0; b_sel = '0; b_oready = 1'b0;
    c_data = '0; c_valid = '0; c_sel = '0; c_oready = 1'b0;
    e_data = '0; e_valid = '0; e_sel = '0; e_oready = 1'b0;
    f_data = '0; f_valid = '0; f_sel = '0; f_oready = 1'b0;
    #2;
    n_total++; if (a_ovalid !== 1'b0) begin n_bad++; $display("FAIL por_out_valid: got %b want 0", a_ovalid); end
    n_total++; if (a_odata !== 24'h0) begin n_bad++; $display("FAIL por_out_data: got %h want 000000", a_odata); end
    n_total++; if (a_grant !== 2'd0) begin n_bad++; $display("FAIL por_grant_idx: got %0d want 0", a_grant); end
    repeat (2) tick();
    reset = 1'b0;
    tick();
    n_total++; if (a_ovalid !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle: got %b want 0", a_ovalid); end
  endtask

  task automatic test_mode0_stream();
    a_sel = 2'd2;
    a_data[71:48] = 24'hABCDEF;
    a_valid = 4'b0100;
    a_oready = 1'b1;
    qa.push_back(24'hABCDEF);
    #1;
    n_total++; if (a_ready !== 4'b0100) begin n_bad++; $display("FAIL m0_in_ready: got %b want 0100", a_ready); end
    tick();
    n_total++; if (a_ovalid !== 1'b1) begin n_bad++; $display("FAIL m0_out_valid: got %b want 1", a_ovalid); end
    n_total++; if (a_grant !== 2'd2) begin n_bad++; $display("FAIL m0_grant: got %0d want 2", a_grant); end
    n_total++; if (a_odata !== qa[0]) begin n_bad++; $display("FAIL m0_out_data: got %h want %h", a_odata, qa[0]); end
    void'(qa.pop_front());
  endtask

  task automatic test_stall();
    // Channel 2 stays valid with a fresh word while the consumer stalls.
    a_data[71:48] = 24'h123456;
    a_oready = 1'b0;
    qa.push_back(24'h123456);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (a_ready !== 4'b0000) begin n_bad++; $display("FAIL stall_in_ready[%0d]: got %b want 0000", i, a_ready); end
      if (i == 2) a_sel = 2'd0;
      tick();
      n_total++; if (a_odata !== 24'hABCDEF) begin n_bad++; $display("FAIL stall_hold_data[%0d]: got %h want abcdef", i, a_odata); end
      n_total++; if (a_ovalid !== 1'b1) begin n_bad++; $display("FAIL stall_hold_valid[%0d]: got %b want 1", i, a_ovalid); end
    end
    a_sel = 2'd2;
    a_oready = 1'b1;
    #1;
    n_total++; if (a_ready !== 4'b0100) begin n_bad++; $display("FAIL release_in_ready: got %b want 0100", a_ready); end
    tick();
    n_total++; if (a_odata !== qa[0]) begin n_bad++; $display("FAIL release_data: got %h want %h", a_odata, qa[0]); end
    void'(qa.pop_front());
    n_total++; if (a_ovalid !== 1'b1) begin n_bad++; $display("FAIL release_valid: got %b want 1", a_ovalid); end
    a_valid = 4'b0000;
    tick();
    n_total++; if (a_ovalid !== 1'b0) begin n_bad++; $display("FAIL drain_valid: got %b want 0", a_ovalid); end
    n_total++; if (a_odata !== 24'h123456) begin n_bad++; $display("FAIL drain_hold_data: got %h want 123456", a_odata); end
  endtask

  task automatic test_reset_midstream();
    a_data[71:48] = 24'h777777;
    a_valid = 4'b0100;
    a_oready = 1'b0;
    tick();
    n_total++; if (a_ovalid !== 1'b1) begin n_bad++; $display("FAIL mid_loaded: got %b want 1", a_ovalid); end
    a_valid = 4'b0000;
    #2;
    reset = 1'b1;
    #1;
    n_total++; if (a_ovalid !== 1'b0) begin n_bad++; $display("FAIL async_rst_valid: got %b want 0", a_ovalid); end
    n_total++; if (a_odata !== 24'h0) begin n_bad++; $display("FAIL async_rst_data: got %h want 000000", a_odata); end
    n_total++; if (a_grant !== 2'd0) begin n_bad++; $display("FAIL async_rst_grant: got %0d want 0", a_grant); end
    tick();
    tick();
    reset = 1'b0;
    a_oready = 1'b1;
    tick();
    n_total++; if (a_ovalid !== 1'b0) begin n_bad++; $display("FAIL rst_discard: got %b want 0", a_ovalid); end
  endtask

  task automatic test_rr_rotation();
    int g;
    for (int i = 0; i < 4; i++) b_data[i*24 +: 24] = 24'hB00000 | 24'(i);
    b_valid = 4'b1111;
    b_oready = 1'b1;
    qg.push_back(0); qg.push_back(1); qg.push_back(2); qg.push_back(3); qg.push_back(0);
    #1;
    n_total++; if (b_ready !== 4'b0001) begin n_bad++; $display("FAIL rr_first_ready: got %b want 0001", b_ready); end
    for (int i = 0; i < 9; i++) begin
      if (i == 5) begin
        b_valid = 4'b1010;
        qg.push_back(1); qg.push_back(3); qg.push_back(1); qg.push_back(3);
      end
      tick();
      g = qg.pop_front();
      n_total++; if (b_ovalid !== 1'b1) begin n_bad++; $display("FAIL rr_valid[%0d]: got %b want 1", i, b_ovalid); end
      n_total++; if (b_grant !== 2'(g)) begin n_bad++; $display("FAIL rr_grant[%0d]: got %0d want %0d", i, b_grant, g); end
      n_total++; if (b_odata !== (24'hB00000 | 24'(g))) begin n_bad++; $display("FAIL rr_data[%0d]: got %h want %h", i, b_odata, 24'hB00000 | 24'(g)); end
    end
    b_valid = 4'b0000;
    tick();
    n_total++; if (b_ovalid !== 1'b0) begin n_bad++; $display("FAIL rr_idle: got %b want 0", b_ovalid); end
  endtask

  task automatic test_invalid_select();
    c_sel = 2'd0;
    c_data[23:0] = 24'h111111;
    c_valid = 3'b001;
    c_oready = 1'b1;
    tick();
    n_total++; if (c_ovalid !== 1'b1) begin n_bad++; $display("FAIL isel_load: got %b want 1", c_ovalid); end
    c_sel = 2'd3;
    c_oready = 1'b0;
    #1;
    n_total++; if (c_ready !== 3'b000) begin n_bad++; $display("FAIL isel_stall_ready: got %b want 000", c_ready); end
    tick();
    n_total++; if (c_ovalid !== 1'b1) begin n_bad++; $display("FAIL isel_held: got %b want 1", c_ovalid); end
    c_oready = 1'b1;
    #1;
    n_total++; if (c_ready !== 3'b000) begin n_bad++; $display("FAIL isel_free_ready: got %b want 000", c_ready); end
    tick();
    n_total++; if (c_ovalid !== 1'b0) begin n_bad++; $display("FAIL isel_drained: got %b want 0", c_ovalid); end
    n_total++; if (c_odata !== 24'h111111) begin n_bad++; $display("FAIL isel_hold_data: got %h want 111111", c_odata); end
    c_valid = 3'b111;
    #1;
    n_total++; if (c_ready !== 3'b000) begin n_bad++; $display("FAIL isel_allvalid_ready: got %b want 000", c_ready); end
    tick();
    n_total++; if (c_ovalid !== 1'b0) begin n_bad++; $display("FAIL isel_stays_empty: got %b want 0", c_ovalid); end
  endtask

  task automatic test_sweep_n5();
    int   rr;
    int   seq[5];
    int   c;
    logic mv, slot, found;
    logic [4:0] exp_r;
    rr = 4;
    for (int i = 0; i < 5; i++) seq[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int ch = 0; ch < 5; ch++) begin
        if (!e_valid[ch] && cyc < 390) e_valid[ch] = ($urandom_range(0, 1) == 1);
        e_data[ch*24 +: 24] = {4'(ch), 20'(seq[ch])};
      end
      if (cyc >= 390) e_valid = 5'b0;
      e_oready = (cyc >= 390) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      mv = (q5.size() != 0);
      n_total++; if (e_ovalid !== mv) begin n_bad++; $display("FAIL n5_valid@%0d: got %b want %b", cyc, e_ovalid, mv); end
      if (mv) begin
        n_total++; if (e_odata !== q5[0].d) begin n_bad++; $display("FAIL n5_data@%0d: got %h want %h", cyc, e_odata, q5[0].d); end
        n_total++; if (e_grant !== 3'(q5[0].ch)) begin n_bad++; $display("FAIL n5_grant@%0d: got %0d want %0d", cyc, e_grant, q5[0].ch); end
      end
      slot = !mv || e_oready;
      found = 1'b0;
      c = 0;
      for (int k = 1; k <= 5; k++) begin
        if (!found && e_valid[(rr + k) % 5]) begin
          found = 1'b1;
          c = (rr + k) % 5;
        end
      end
      exp_r = (found && slot) ? 5'(1 << c) : 5'b0;
      n_total++; if (e_ready !== exp_r) begin n_bad++; $display("FAIL n5_ready@%0d: got %b want %b", cyc, e_ready, exp_r); end
      if (mv && e_oready) void'(q5.pop_front());
      if (found && slot) begin
        q5.push_back('{ch: c, d: {4'(c), 20'(seq[c])}});
        rr = c;
        seq[c]++;
      end
      tick();
      if (found && slot) e_valid[c] = 1'b0;
    end
    n_total++; if (e_ovalid !== 1'b0) begin n_bad++; $display("FAIL n5_final_empty: got %b want 0", e_ovalid); end
  endtask

  task automatic test_sweep_n1();
    int   seq;
    logic mv, slot, xfer;
    seq = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (!f_valid[0] && cyc < 190) f_valid[0] = ($urandom_range(0, 1) == 1);
      if (cyc >= 190) f_valid[0] = 1'b0;
      f_data = 8'(seq);
      f_oready = (cyc >= 190) ? 1'b1 : ($urandom_range(0, 2) != 0);
      #1;
      mv = (q1.size() != 0);
      n_total++; if (f_ovalid !== mv) begin n_bad++; $display("FAIL n1_valid@%0d: got %b want %b", cyc, f_ovalid, mv); end
      if (mv) begin
        n_total++; if (f_odata !== q1[0]) begin n_bad++; $display("FAIL n1_data@%0d: got %h want %h", cyc, f_odata, q1[0]); end
        n_total++; if (f_grant !== 1'b0) begin n_bad++; $display("FAIL n1_grant@%0d: got %0d want 0", cyc, f_grant); end
      end
      slot = !mv || f_oready;
      n_total++; if (f_ready !== slot) begin n_bad++; $display("FAIL n1_ready@%0d: got %b want %b", cyc, f_ready, slot); end
      xfer = slot && f_valid[0];
      if (mv && f_oready) void'(q1.pop_front());
      if (xfer) begin
        q1.push_back(8'(seq));
        seq++;
      end
      tick();
      if (xfer) f_valid[0] = 1'b0;
    end
    n_total++; if (f_ovalid !== 1'b0) begin n_bad++; $display("FAIL n1_final_empty: got %b want 0", f_ovalid); end
  endtask

  initial begin
    test_reset();
    test_mode0_stream();
    test_stall();
    test_reset_midstream();
    test_rr_rotation();
    test_invalid_select();
    test_sweep_n5();
    test_sweep_n1();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
